// File: rtl/invaders_irq_gen.sv
// Space Invaders video timing and RST 1/RST 2 interrupt source for the i8080.
// Optional miss counter: define INVADERS_IRQ_MISS_CNT_EN to add miss_count.
module invaders_irq_gen #(
  parameter int H_TOTAL     = 320,
  parameter int V_TOTAL     = 262,
  parameter int MID_LINE    = 96,
  parameter int VBLANK_LINE = 224,
  parameter int CLK_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inte,
  input  logic       inta,
  output logic       int_req,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       vblank
`ifdef INVADERS_IRQ_MISS_CNT_EN
  ,
  output logic [7:0] miss_count
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [8:0] H_MAX = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_MAX = 9'(V_TOTAL - 1);
  localparam logic [8:0] MID_V = 9'(MID_LINE);
  localparam logic [8:0] VB_V  = 9'(VBLANK_LINE);
  localparam logic [7:0] OP_RST1 = 8'hCF;
  localparam logic [7:0] OP_RST2 = 8'hD7;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  logic [DW-1:0] div_q;
  logic          tick;
  logic          h_wrap;
  logic [8:0]    h_next;
  logic [8:0]    v_next;
  logic          ev1;
  logic          ev2;
  logic          pend1;
  logic          pend2;
  logic          set1;
  logic          set2;
  logic          clr1;
  logic          clr2;
  logic          inta_q;
  logic          inta_rise;
  state_t        state_q;
  state_t        state_d;
  logic          sel_q;
  logic          sel_d;
  logic [7:0]    dout_d;
  logic          doe_d;

  assign tick   = (div_q == DIV_MAX);
  assign h_wrap = (hcount == H_MAX);
  assign h_next = h_wrap ? 9'd0 : hcount + 9'd1;

  always_comb begin
    v_next = vcount;
    if (h_wrap) begin
      v_next = (vcount == V_MAX) ? 9'd0 : vcount + 9'd1;
    end
  end

  assign ev1 = tick && (h_next == 9'd0) && (v_next == MID_V);
  assign ev2 = tick && (h_next == 9'd0) && (v_next == VB_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= 9'd0;
      vcount <= 9'd0;
      vblank <= 1'b0;
    end else if (tick) begin
      hcount <= h_next;
      vcount <= v_next;
      vblank <= (v_next >= VB_V);
    end
  end

  // A bit being cleared this edge can be re-armed by a fresh event.
  assign set1 = ev1 && inte && (!pend1 || clr1);
  assign set2 = ev2 && inte && (!pend2 || clr2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend1   <= 1'b0;
      pend2   <= 1'b0;
      int_req <= 1'b0;
    end else begin
      pend1   <= (pend1 && !clr1) || set1;
      pend2   <= (pend2 && !clr2) || set2;
      int_req <= pend1 || pend2;
    end
  end

  assign inta_rise = inta && !inta_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dout_d  = data_out;
    doe_d   = data_oe;
    clr1    = 1'b0;
    clr2    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inta_rise && int_req) begin
          sel_d   = pend2;
          dout_d  = pend2 ? OP_RST2 : OP_RST1;
          doe_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!inta) begin
          clr1    = !sel_q;
          clr2    = sel_q;
          dout_d  = 8'h00;
          doe_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      inta_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_out <= dout_d;
      data_oe  <= doe_d;
      inta_q   <= inta;
    end
  end

`ifdef INVADERS_IRQ_MISS_CNT_EN
  logic drop1;
  logic drop2;

  assign drop1 = ev1 && !set1;
  assign drop2 = ev2 && !set2;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count <= 8'h00;
    end else if ((drop1 || drop2) && (miss_count != 8'hFF)) begin
      miss_count <= miss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_invaders_irq_gen.sv
// Bench for invaders_irq_gen: directed frame/interrupt steps plus random
// inte/inta traffic, all checked against an arithmetic beam/interrupt model.
module tb_invaders_irq_gen;

  localparam int H  = 8;
  localparam int V  = 10;
  localparam int MID = 3;
  localparam int VB = 7;
  localparam int D  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inte = 1'b0;
  logic       inta = 1'b0;
  logic       int_req;
  logic [7:0] data_out;
  logic       data_oe;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       vblank;
`ifdef INVADERS_IRQ_MISS_CNT_EN
  logic [7:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  int         c = 0;
  int         pos = 0;
  bit         m_p1, m_p2, m_req, m_ack, m_sel, m_oe, m_inta_q;
  logic [7:0] m_dout;
  int         m_miss;

  invaders_irq_gen #(
    .H_TOTAL(H),
    .V_TOTAL(V),
    .MID_LINE(MID),
    .VBLANK_LINE(VB),
    .CLK_DIV(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inte(inte),
    .inta(inta),
    .int_req(int_req),
    .data_out(data_out),
    .data_oe(data_oe),
    .hcount(hcount),
    .vcount(vcount),
    .vblank(vblank)
`ifdef INVADERS_IRQ_MISS_CNT_EN
    ,
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit p1, p2, req, e1, e2, c1, c2, tk;
    if (rst) begin
      c = 0; pos = 0;
      m_p1 = 0; m_p2 = 0; m_req = 0; m_ack = 0; m_sel = 0;
      m_oe = 0; m_dout = 8'h00; m_miss = 0; m_inta_q = 0;
      return;
    end
    p1 = m_p1; p2 = m_p2; req = m_req;
    c++;
    tk  = (c % D) == 0;
    pos = (c / D) % (H * V);
    e1  = tk && (pos == MID * H);
    e2  = tk && (pos == VB * H);
    c1  = m_ack && !inta && !m_sel;
    c2  = m_ack && !inta && m_sel;
    if (m_ack) begin
      if (!inta) begin
        m_ack = 0; m_oe = 0; m_dout = 8'h00;
      end
    end else if (inta && !m_inta_q && req) begin
      m_sel = p2;
      m_dout = p2 ? 8'hD7 : 8'hCF;
      m_oe = 1; m_ack = 1;
    end
    if (e1 && (!inte || (p1 && !c1)) && m_miss < 255) m_miss++;
    if (e2 && (!inte || (p2 && !c2)) && m_miss < 255) m_miss++;
    m_p1 = (p1 && !c1) || (e1 && inte);
    m_p2 = (p2 && !c2) || (e2 && inte);
    m_req = p1 || p2;
    m_inta_q = inta;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("hcount", hcount, pos % H);
    chk("vcount", vcount, pos / H);
    chk("vblank", vblank, (pos / H) >= VB);
    chk("int_req", int_req, m_req);
    chk("data_oe", data_oe, m_oe);
    chk("data_out", data_out, m_dout);
`ifdef INVADERS_IRQ_MISS_CNT_EN
    chk("miss_count", miss_count, m_miss);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 1000 && c < target; i++) step();
    chk("run_to", c, target);
  endtask

  initial begin
    // reset state
    inte = 1'b0; inta = 1'b0;
    do_reset();
    chk("rst_h", hcount, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 8'h00);

    // timing: line wrap after 16 clks, frame after 160
    run_to(16);
    chk("hwrap_h", hcount, 0);
    chk("hwrap_v", vcount, 1);
    run_to(111);
    chk("vb_pre", vblank, 0);
    step();
    chk("vb_on", vblank, 1);
    run_to(160);
    chk("frame_h", hcount, 0);
    chk("frame_v", vcount, 0);
    chk("frame_vb", vblank, 0);

    // mid-screen interrupt
    do_reset();
    inte = 1'b1;
    run_to(48);
    chk("mid_v", vcount, 3);
    chk("mid_req0", int_req, 0);
    step();
    chk("mid_req1", int_req, 1);
    inta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_oe", data_oe, 1);
      chk("mid_op", data_out, 8'hCF);
    end
    inta = 1'b0;
    step();
    chk("mid_oe_off", data_oe, 0);
    step();
    chk("mid_req_off", int_req, 0);

    // vblank interrupt
    run_to(113);
    chk("vbi_req", int_req, 1);
    inta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("vbi_op", data_out, 8'hD7);
    end
    inta = 1'b0;
    step();
    step();
    chk("vbi_req_off", int_req, 0);

    // priority: both pending
    do_reset();
    inte = 1'b1;
    run_to(113);
    inta = 1'b1;
    step();
    chk("pri_op1", data_out, 8'hD7);
    step();
    inta = 1'b0;
    step(); step(); step();
    chk("pri_req_hold", int_req, 1);
    inta = 1'b1;
    step();
    chk("pri_op2", data_out, 8'hCF);
    inta = 1'b0;
    step(); step(); step();
    chk("pri_req_off", int_req, 0);

    // disabled interrupts
    do_reset();
    inte = 1'b0;
    run_to(49);
    chk("dis_req", int_req, 0);
`ifdef INVADERS_IRQ_MISS_CNT_EN
    chk("dis_miss", miss_count, 1);
`endif
    run_to(160);
    chk("dis_req_end", int_req, 0);

    // reset mid-ACK
    do_reset();
    inte = 1'b1;
    run_to(49);
    inta = 1'b1;
    step();
    chk("rack_oe", data_oe, 1);
    rst = 1'b1;
    step();
    chk("rack_oe0", data_oe, 0);
    chk("rack_req0", int_req, 0);
    chk("rack_h", hcount, 0);
    chk("rack_v", vcount, 0);
    rst = 1'b0;
    inta = 1'b0;

    // random inte/inta traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      inte = ($urandom_range(0, 3) != 0);
      if (inta) inta = ($urandom_range(0, 2) != 0);
      else      inta = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
